gate_operand_loader: RTL and testbench

- Serial-to-parallel operand stage sitting directly upstream of the combinational gate-array test stage.
- Shifts in one frame of two W-bit bus operands plus four control bits (x1, x2, a, b) and presents them as stable registered outputs.
- Waits a settle interval, captures the downstream stage's bus result and scalar result, then offers them on a valid/ready result interface.
- Lets the gate stage be exercised from a 1-bit source such as a board switch, pin or testbench.

---
 rtl/gate_stage_pkg.sv | 41 ++++
 rtl/gate_serial_shreg.sv | 51 +++++
 rtl/gate_operand_loader.sv | 183 ++++++++++++++++++
 tb/tb_gate_operand_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_stage_pkg.sv
// ============================================================================
// Module      : gate_stage_pkg
// Description : Shared definitions for the gate-stage operand loader: FSM
//               state encoding, frame length and the bit positions of the
//               operand and control fields inside a fully shifted frame.
//               PARITY_CHECK_EN appends one trailing even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_stage_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

`ifdef PARITY_CHECK_EN
    localparam int c_parity_bits = 1;
`else
    localparam int c_parity_bits = 0;
`endif

    // Bits arrive MSB-first and are shifted in at bit 0, so the last bit of
    // the frame ends up at index 0 and the first bit at the top.
    localparam int c_idx_b  = c_parity_bits + 0;
    localparam int c_idx_a  = c_parity_bits + 1;
    localparam int c_idx_x2 = c_parity_bits + 2;
    localparam int c_idx_x1 = c_parity_bits + 3;
    localparam int c_op_lsb = c_parity_bits + 4;

    function automatic int frame_len(input int w);
        return 2 * w + 4 + c_parity_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_serial_shreg.sv
// ============================================================================
// Module      : gate_serial_shreg
// Description : Serial shift register for one operand frame with a bit
//               counter and a frame-complete strobe.
//   clk, rst       : clock, synchronous active-high reset
//   i_bit/i_valid  : serial data bit and its qualifier
//   i_enable       : bits are only accepted while high
//   o_frame_next   : frame contents including the bit being accepted now
//   o_frame_done   : high in the cycle whose edge accepts the last bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_serial_shreg #(
    parameter int FRAME_LEN = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_bit,
    input  logic                 i_valid,
    input  logic                 i_enable,
    output logic [FRAME_LEN-1:0] o_frame_next,
    output logic                 o_frame_done
);

    localparam int                 c_cnt_w = $clog2(FRAME_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FRAME_LEN - 1);

    // Only FRAME_LEN-1 bits need storing: the final bit is taken straight
    // from the serial input on the completing edge.
    logic [FRAME_LEN-2:0] r_shreg;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_accept;

    assign w_accept     = i_valid & i_enable;
    assign o_frame_next = {r_shreg, i_bit};
    assign o_frame_done = w_accept && (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_shreg <= o_frame_next[FRAME_LEN-2:0];
            r_count <= o_frame_done ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gate_operand_loader.sv
// ============================================================================
// Module      : gate_operand_loader
// Description : Serial-to-parallel operand stage for the combinational gate
//               test stage. Shifts in op_1, op_2, x1, x2, a, b (MSB-first),
//               presents them as registered outputs, waits SETTLE_CYCLES,
//               captures y_bus_i / y_i and offers them via valid/ready.
//   clk, rst                 : clock, synchronous active-high reset
//   ser_in, ser_valid        : serial frame input
//   busy                     : high whenever not IDLE
//   op_1, op_2, x1_o..b_o    : operands to the downstream stage
//   y_bus_i, y_i             : results returned by the downstream stage
//   result_bus, result_y     : captured results
//   result_valid/ready       : result handshake
//   frame_err                : parity failure pulse (PARITY_CHECK_EN only)
// Macro       : PARITY_CHECK_EN adds a trailing even-parity bit and frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_operand_loader
    import gate_stage_pkg::*;
#(
    parameter int W             = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ser_in,
    input  logic         ser_valid,
    output logic         busy,
    output logic [W-1:0] op_1,
    output logic [W-1:0] op_2,
    output logic         x1_o,
    output logic         x2_o,
    output logic         a_o,
    output logic         b_o,
    input  logic [W-1:0] y_bus_i,
    input  logic         y_i,
    output logic [W-1:0] result_bus,
    output logic         result_y,
    output logic         result_valid,
`ifdef PARITY_CHECK_EN
    output logic         frame_err,
`endif
    input  logic         result_ready
);

    localparam int         c_frame       = frame_len(W);
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES);

    state_t             r_state;
    logic [3:0]         r_settle_cnt;
    logic               r_busy;
    logic [W-1:0]       r_op_1;
    logic [W-1:0]       r_op_2;
    logic               r_x1;
    logic               r_x2;
    logic               r_a;
    logic               r_b;
    logic [W-1:0]       r_result_bus;
    logic               r_result_y;
    logic               r_result_valid;
    logic [c_frame-1:0] w_frame;
    logic               w_frame_done;
    logic               w_shift_en;
    logic               w_parity_ok;

    // Bits are only taken while collecting a frame; anything offered while a
    // result is settling or pending is dropped.
    assign w_shift_en = (r_state == IDLE) || (r_state == SHIFT);

    gate_serial_shreg #(
        .FRAME_LEN (c_frame)
    ) u_shreg (
        .clk          (clk),
        .rst          (rst),
        .i_bit        (ser_in),
        .i_valid      (ser_valid),
        .i_enable     (w_shift_en),
        .o_frame_next (w_frame),
        .o_frame_done (w_frame_done)
    );

`ifdef PARITY_CHECK_EN
    logic r_frame_err;
    assign w_parity_ok = ~(^w_frame);
    assign frame_err   = r_frame_err;
`else
    assign w_parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_settle_cnt   <= '0;
            r_busy         <= 1'b0;
            r_op_1         <= '0;
            r_op_2         <= '0;
            r_x1           <= 1'b0;
            r_x2           <= 1'b0;
            r_a            <= 1'b0;
            r_b            <= 1'b0;
            r_result_bus   <= '0;
            r_result_y     <= 1'b0;
            r_result_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_frame_err    <= 1'b0;
`endif
        end else begin
`ifdef PARITY_CHECK_EN
            r_frame_err <= 1'b0;
`endif
            case (r_state)
                IDLE, SHIFT: begin
                    if (w_frame_done) begin
                        if (w_parity_ok) begin
                            // All operands switch together on the completing edge.
                            r_op_1       <= w_frame[c_op_lsb+W +: W];
                            r_op_2       <= w_frame[c_op_lsb +: W];
                            r_x1         <= w_frame[c_idx_x1];
                            r_x2         <= w_frame[c_idx_x2];
                            r_a          <= w_frame[c_idx_a];
                            r_b          <= w_frame[c_idx_b];
                            r_settle_cnt <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= SETTLE;
                        end else begin
`ifdef PARITY_CHECK_EN
                            r_frame_err <= 1'b1;
`endif
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (ser_valid) begin
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SETTLE: begin
                    // Counting 0..SETTLE_CYCLES puts result_valid SETTLE_CYCLES+2
                    // edges after the completing edge.
                    if (r_settle_cnt == c_settle_last) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_result_bus   <= y_bus_i;
                    r_result_y     <= y_i;
                    r_result_valid <= 1'b1;
                    r_state        <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_result_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign op_1         = r_op_1;
    assign op_2         = r_op_2;
    assign x1_o         = r_x1;
    assign x2_o         = r_x2;
    assign a_o          = r_a;
    assign b_o          = r_b;
    assign result_bus   = r_result_bus;
    assign result_y     = r_result_y;
    assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_gate_operand_loader.sv
// ============================================================================
// Module      : tb_gate_operand_loader
// Description : Self-checking bench for gate_operand_loader. A stand-in
//               downstream stage computes y_bus = op_1 & op_2 and
//               y = (x1 & b) | (x2 & a). Honours PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_operand_loader;

    localparam int W = 16;
    localparam int S = 1;
`ifdef PARITY_CHECK_EN
    localparam int FL = 2 * W + 5;
`else
    localparam int FL = 2 * W + 4;
`endif

    logic         clk          = 1'b0;
    logic         rst          = 1'b1;
    logic         ser_in       = 1'b0;
    logic         ser_valid    = 1'b0;
    logic         result_ready = 1'b0;
    logic         busy;
    logic [W-1:0] op_1;
    logic [W-1:0] op_2;
    logic         x1_o;
    logic         x2_o;
    logic         a_o;
    logic         b_o;
    logic [W-1:0] y_bus_i;
    logic         y_i;
    logic [W-1:0] result_bus;
    logic         result_y;
    logic         result_valid;
`ifdef PARITY_CHECK_EN
    logic         frame_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    assign y_bus_i = op_1 & op_2;
    assign y_i     = (x1_o & b_o) | (x2_o & a_o);

    gate_operand_loader #(
        .W             (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ser_in       (ser_in),
        .ser_valid    (ser_valid),
        .busy         (busy),
        .op_1         (op_1),
        .op_2         (op_2),
        .x1_o         (x1_o),
        .x2_o         (x2_o),
        .a_o          (a_o),
        .b_o          (b_o),
        .y_bus_i      (y_bus_i),
        .y_i          (y_i),
        .result_bus   (result_bus),
        .result_y     (result_y),
        .result_valid (result_valid),
`ifdef PARITY_CHECK_EN
        .frame_err    (frame_err),
`endif
        .result_ready (result_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_op1, m_op2, m_rbus;
    logic         m_x1, m_x2, m_a, m_b, m_ry, m_valid, m_busy, m_err;
    bit           m_q[$];
    bit           m_accepting;
    int           m_since;
    logic [FL-1:0] m_v;

    always @(posedge clk) begin
        m_err = 1'b0;
        if (rst) begin
            m_op1 = '0; m_op2 = '0; m_rbus = '0;
            m_x1 = 0; m_x2 = 0; m_a = 0; m_b = 0; m_ry = 0;
            m_valid = 0; m_busy = 0; m_accepting = 1; m_since = -1;
            m_q.delete();
        end else if (m_valid && result_ready) begin
            m_valid = 0; m_busy = 0; m_accepting = 1;
        end else if (m_accepting && ser_valid) begin
            m_q.push_back(ser_in);
            m_busy = 1;
            if (m_q.size() == FL) begin
                m_v = '0;
                foreach (m_q[i]) m_v = {m_v[FL-2:0], m_q[i]};
                m_q.delete();
`ifdef PARITY_CHECK_EN
                if (^m_v) begin
                    m_err = 1; m_busy = 0;
                end else
`endif
                begin
                    // frame order: op_1, op_2, x1, x2, a, b [, parity]
                    m_op1 = m_v[FL-1 -: W];
                    m_op2 = m_v[FL-1-W -: W];
                    m_x1  = m_v[FL-1-2*W];
                    m_x2  = m_v[FL-2-2*W];
                    m_a   = m_v[FL-3-2*W];
                    m_b   = m_v[FL-4-2*W];
                    m_accepting = 0;
                    m_since = 0;
                end
            end
        end else if (m_since >= 0) begin
            m_since++;
            if (m_since == S + 2) begin
                m_valid = 1;
                m_rbus  = m_op1 & m_op2;
                m_ry    = (m_x1 & m_b) | (m_x2 & m_a);
                m_since = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("op_1", 32'(op_1), 32'(m_op1));
            check("op_2", 32'(op_2), 32'(m_op2));
            check("ctrl", 32'({x1_o, x2_o, a_o, b_o}), 32'({m_x1, m_x2, m_a, m_b}));
            check("busy", 32'(busy), 32'(m_busy));
            check("result_valid", 32'(result_valid), 32'(m_valid));
            check("result_bus", 32'(result_bus), 32'(m_rbus));
            check("result_y", 32'(result_y), 32'(m_ry));
`ifdef PARITY_CHECK_EN
            check("frame_err", 32'(frame_err), 32'(m_err));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FL-1:0] make_frame(input logic [W-1:0] o1, input logic [W-1:0] o2,
                                                  input logic x1, input logic x2,
                                                  input logic a, input logic b);
        logic [2*W+3:0] core;
        core = {o1, o2, x1, x2, a, b};
`ifdef PARITY_CHECK_EN
        return {core, ^core};
`else
        return core;
`endif
    endfunction

    task automatic send_bits(input logic [FL-1:0] f, input int first, input int last_excl,
                             input int gap_at, input int gap_len);
        for (int i = first; i < last_excl; i++) begin
            if (i == gap_at) begin
                ser_valid = 1'b0;
                repeat (gap_len) begin
                    tick();
                    check("busy_in_gap", 32'(busy), 32'd1);
                end
            end
            ser_valid = 1'b1;
            ser_in    = f[FL-1-i];
            tick();
        end
        ser_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (result_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("valid_after_hs", 32'(result_valid), 32'd0);
    endtask

    initial begin
        logic [FL-1:0] f;
        int lat;

        // Reset
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_op_1", 32'(op_1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);

        // Basic frame and latency
        f = make_frame(16'hF0F0, 16'h0FF0, 1, 0, 0, 1);
        send_bits(f, 0, FL, -1, 0);
        check("op_1_at_completion", 32'(op_1), 32'h0000F0F0);
        check("op_2_at_completion", 32'(op_2), 32'h00000FF0);
        wait_valid(20, lat);
        check("latency", 32'(lat), 32'(S + 2));
        check("res_bus_A", 32'(result_bus), 32'h000000F0);
        check("res_y_A", 32'(result_y), 32'd1);
        handshake();

        // Same frame with a 5-cycle pause mid-frame
        send_bits(f, 0, FL, 10, 5);
        wait_valid(20, lat);
        check("res_bus_gap", 32'(result_bus), 32'h000000F0);
        check("res_y_gap", 32'(result_y), 32'd1);

        // Back-pressure in DONE with serial activity that must be ignored
        for (int i = 0; i < 10; i++) begin
            ser_valid = i[0];
            ser_in    = 1'b1;
            tick();
            check("valid_held", 32'(result_valid), 32'd1);
            check("op_1_held_done", 32'(op_1), 32'h0000F0F0);
        end
        ser_valid    = 1'b1;
        result_ready = 1'b1;
        tick();
        ser_valid    = 1'b0;
        result_ready = 1'b0;
        check("idle_after_hs", 32'(busy), 32'd0);
        check("valid_dropped", 32'(result_valid), 32'd0);
        repeat (2) tick();

        // Reset after 20 bits, then a fresh frame
        f = make_frame(16'hFFFF, 16'h1234, 0, 0, 1, 0);
        send_bits(f, 0, 20, -1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_op_1", 32'(op_1), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rbus", 32'(result_bus), 32'd0);
        send_bits(f, 0, FL, -1, 0);
        wait_valid(20, lat);
        check("res_bus_B", 32'(result_bus), 32'h00001234);
        check("res_y_B", 32'(result_y), 32'd0);
        handshake();

        // Back-to-back frame: old operands held until completion edge
        f = make_frame(16'hA5A5, 16'h3C3C, 0, 1, 1, 0);
        send_bits(f, 0, FL - 1, -1, 0);
        check("op_1_hold_b2b", 32'(op_1), 32'h0000FFFF);
        check("op_2_hold_b2b", 32'(op_2), 32'h00001234);
        send_bits(f, FL - 1, FL, -1, 0);
        check("op_1_new_b2b", 32'(op_1), 32'h0000A5A5);
        wait_valid(20, lat);
        check("res_bus_C", 32'(result_bus), 32'h00002424);
        check("res_y_C", 32'(result_y), 32'd1);
        handshake();

`ifdef PARITY_CHECK_EN
        // Wrong parity: error pulse, no result, operands kept
        f = make_frame(16'h1111, 16'h2222, 1, 1, 1, 1);
        f[0] = ~f[0];
        send_bits(f, 0, FL, -1, 0);
        check("frame_err_pulse", 32'(frame_err), 32'd1);
        tick();
        check("frame_err_clear", 32'(frame_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_valid_bad_par", 32'(result_valid), 32'd0);
        end
        check("op_1_kept_bad_par", 32'(op_1), 32'h0000A5A5);
        check("busy_bad_par", 32'(busy), 32'd0);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
